compare_unit: RTL and testbench
===============================

Name: compare_unit

Overview:
Registered magnitude comparator that evaluates two WIDTH-bit operands under both unsigned and two's-complement signed interpretation in the same cycle. It produces per-interpretation flag words plus the signed maximum. It sits in the datapath wherever branch or select logic needs both orderings at once, e.g. slt/sltu-style decisions. All outputs are registered, giving one cycle of latency.

Parameters:
WIDTH, 4, operand and result width in bits; legal range is WIDTH >= 4.

Ports:
clk    input   1      system clock; all state updates on the rising edge
reset  input   1      synchronous, active-high reset
a      input   WIDTH  operand A, read as unsigned for ans1 and as two's-complement for ans2/ans3
b      input   WIDTH  operand B, same interpretation as a
ans1   output  WIDTH  unsigned comparison flag word (registered)
ans2   output  WIDTH  signed comparison flag word (registered)
ans3   output  WIDTH  signed maximum of a and b (registered)

Interface decision: one clock; reset is synchronous and active-high (ports clk, reset).

Behaviour:
- Sampling and latency
  - a and b are sampled on each rising clk edge.
  - Results appear on the outputs after that same edge: latency is 1 cycle, throughput is 1 per cycle.
  - No handshake; a new comparison starts every cycle.
- Reset
  - reset=1 at a rising edge forces ans1=0, ans2=0, ans3=0.
  - Reset has priority over the operands.
  - Reset asserted mid-stream discards the in-flight sample.
  - The first valid result is the one registered at the first edge with reset=0.
- Flag word layout (ans1 and ans2)
  - bit0 = GT (a > b)
  - bit1 = EQ (a == b)
  - bit2 = LT (a < b)
  - bit3 = DIS: signed and unsigned orderings disagree, i.e. exactly one of a and b has MSB=1 and a != b
  - bits [WIDTH-1:4] = 0
- ans1 flags use the unsigned ordering; ans2 flags use the signed ordering. DIS is identical in both words.
- Exactly one of GT/EQ/LT is 1 in each word after reset is released.
- ans3 = a if $signed(a) >= $signed(b), else b; the result is a WIDTH-bit bit pattern.
- Boundary cases
  - Equal operands: EQ=1, DIS=0, ans3=a.
  - Most-negative vs most-positive: unsigned GT, signed LT, DIS=1.
  - All-ones vs zero: unsigned GT, signed LT, DIS=1.
- Combinational logic only between the input sample and the output registers; no internal state beyond those registers.
- Outputs hold their value until the next rising edge.
- Before the first reset, output values are undefined; the bench must apply reset first.

Test Plan:
- Reset: reset=1 for 2 cycles with a=5, b=3 -> ans1=0000, ans2=0000, ans3=0000. Release reset -> next edge gives ans1=0001, ans2=0001, ans3=0101.
- Positive operands: a=3, b=1 -> after 1 edge ans1=0001, ans2=0001, ans3=0011. Displaying in the same timestep as the input change must still show the previous values.
- Sign disagreement: a=4'b1110 (-2), b=1 -> ans1=1001, ans2=1100, ans3=0001. Also a=8, b=7 -> ans1=1001, ans2=1100, ans3=0111.
- Both negative and equality:
  - a=4'b1111, b=4'b1000 -> ans1=0001, ans2=0001, ans3=1111.
  - a=b=0 -> ans1=0010, ans2=0010, ans3=0000.
- Reset mid-stream: apply a=4'b1110, b=1 and assert reset on that same edge -> outputs 0. Next edge with reset=0 -> ans1=1001, ans2=1100, ans3=0001.
- Exhaustive WIDTH=4 sweep: all 256 (a,b) pairs streamed back-to-back. Each result is checked one cycle later against a reference model; exactly one of GT/EQ/LT is set and DIS = (unsigned GT) XOR (signed GT).

Source files
------------

// File: rtl/compare_unit.sv
// compare_unit
//   Registered magnitude comparator. Both operands are compared under the
//   unsigned and the two's-complement signed interpretation in the same cycle.
//   One cycle of latency and one result per cycle. There is no handshake.
//
// Ports
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high; clears every output register
//   a, b   : WIDTH-bit operands
//   ans1   : unsigned flag word  {0.., DIS, LT, EQ, GT}
//   ans2   : signed flag word    {0.., DIS, LT, EQ, GT}
//   ans3   : signed maximum of a and b (a when the two are equal)
module compare_unit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] ans1,
    output logic [WIDTH-1:0] ans2,
    output logic [WIDTH-1:0] ans3
);

    logic             eq;
    logic             ugt;
    logic             ult;
    logic             sgt;
    logic             slt;
    logic             dis;
    logic [WIDTH-1:0] uflags;
    logic [WIDTH-1:0] sflags;
    logic [WIDTH-1:0] smax;

    always_comb begin
        eq  = (a == b);
        ugt = (a > b);
        ult = (a < b);
        sgt = ($signed(a) > $signed(b));
        slt = ($signed(a) < $signed(b));
        // The two orderings disagree only when the sign bits differ.
        // Differing MSBs already imply that a != b.
        dis = a[WIDTH-1] ^ b[WIDTH-1];

        uflags    = '0;
        uflags[0] = ugt;
        uflags[1] = eq;
        uflags[2] = ult;
        uflags[3] = dis;

        sflags    = '0;
        sflags[0] = sgt;
        sflags[1] = eq;
        sflags[2] = slt;
        sflags[3] = dis;

        smax = slt ? b : a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ans1 <= '0;
            ans2 <= '0;
            ans3 <= '0;
        end else begin
            ans1 <= uflags;
            ans2 <= sflags;
            ans3 <= smax;
        end
    end

endmodule

// File: tb/tb_compare_unit.sv
// tb_compare_unit
//   Scoreboard bench for compare_unit (WIDTH=4). The stimulus process drives
//   operands at the falling edge. For each operand pair it pushes the expected
//   outputs, which come from an integer reference model. The monitor pops one
//   entry after each rising edge and compares it with the DUT outputs.
module tb_compare_unit;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ans1;
    logic [W-1:0] ans2;
    logic [W-1:0] ans3;

    typedef struct {
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        logic [W-1:0] e3;
        string        tag;
    } exp_t;

    exp_t   sbq[$];
    exp_t   last_exp;
    bit     have_last = 1'b0;
    int     vectors   = 0;
    int     miscompares = 0;

    compare_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .ans1  (ans1),
        .ans2  (ans2),
        .ans3  (ans3)
    );

    always #5 clk = ~clk;

    // Reference model: compare plain integers and assemble the flag words.
    function automatic exp_t model(input bit r, input int av, input int bv, input string tag);
        exp_t e;
        int   sa;
        int   sb;
        int   ugt;
        int   ueq;
        int   ult;
        int   sgt;
        int   slt;
        int   dis;
        e.tag = tag;
        if (r) begin
            e.e1 = 0;
            e.e2 = 0;
            e.e3 = 0;
            return e;
        end
        sa  = (av >= 8) ? av - 16 : av;
        sb  = (bv >= 8) ? bv - 16 : bv;
        ugt = (av > bv) ? 1 : 0;
        ueq = (av == bv) ? 1 : 0;
        ult = (av < bv) ? 1 : 0;
        sgt = (sa > sb) ? 1 : 0;
        slt = (sa < sb) ? 1 : 0;
        dis = (ugt != sgt) ? 1 : 0;
        e.e1 = W'(ugt + 2 * ueq + 4 * ult + 8 * dis);
        e.e2 = W'(sgt + 2 * ueq + 4 * slt + 8 * dis);
        e.e3 = (sa >= sb) ? W'(av) : W'(bv);
        return e;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%b required=%b (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one sample and queue the expected result for the next rising edge.
    // Right after the inputs change, the outputs must still show the previous result.
    task automatic apply(input bit r, input int av, input int bv, input string tag);
        @(negedge clk);
        reset = r;
        a     = W'(av);
        b     = W'(bv);
        sbq.push_back(model(r, av, bv, tag));
        if (have_last) begin
            #0;
            check({tag, "/hold_ans1"}, ans1, last_exp.e1);
            check({tag, "/hold_ans3"}, ans3, last_exp.e3);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check({e.tag, "/ans1"}, ans1, e.e1);
                check({e.tag, "/ans2"}, ans2, e.e2);
                check({e.tag, "/ans3"}, ans3, e.e3);
                last_exp  = e;
                have_last = 1'b1;
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        reset = 1'b1;
        a     = '0;
        b     = '0;
        apply(1, 5, 3, "reset0");
        apply(1, 5, 3, "reset1");
        apply(0, 5, 3, "release");
        apply(0, 3, 1, "pos");
        apply(0, 14, 1, "neg_vs_pos");
        apply(0, 8, 7, "minneg_vs_maxpos");
        apply(0, 15, 8, "both_neg");
        apply(0, 0, 0, "eq_zero");
        apply(0, 15, 0, "ones_vs_zero");
        apply(0, 6, 6, "eq_pos");
        apply(0, 9, 9, "eq_neg");
        apply(1, 14, 1, "midreset");
        apply(0, 14, 1, "after_midreset");
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                apply(0, i, j, "sweep");
            end
        end
        for (int k = 0; k < 200; k++) begin
            apply((($urandom % 16) == 0), int'($urandom_range(15, 0)),
                  int'($urandom_range(15, 0)), "rand");
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: actual=%0d pending required=0", sbq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
